// File: rtl/rptr_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, registered empty flag, RAM read issue and a 2-entry output buffer.
// Optional read-level counter is enabled by defining ASYNC_FIFO_RLEVEL_EN (default build ties rlevel to 0).
module rptr_rd_ctrl #(
  parameter int ASIZE    = 4,
  parameter int DSIZE    = 8,
  parameter int AE_LEVEL = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             mem_ren,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             rempty,
  output logic [ASIZE:0]   rlevel,
  output logic             ralmost_empty
);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ASIZE:0]   rbin_q, rbin_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic             inflight_q;
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             pop_s;
  logic [2:0]       occ_sum_s;
  logic [1:0]       occ_after_pop_s;

  assign m_valid   = (occ_q != 2'd0);
  assign pop_s     = m_valid & m_ready;
  // Buffer words still owed after this cycle: held + arriving - leaving.
  assign occ_sum_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign mem_ren   = !rempty_q && (occ_sum_s < 3'd2);
  assign occ_after_pop_s = occ_q - {1'b0, pop_s};

  // Pointer advance and empty detection against the synchronized write pointer.
  always_comb begin
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, mem_ren};
    rptr_d   = bin2gray(rbin_d);
    rempty_d = (rptr_d == rq2_wptr);
  end

  // Output buffer: arrivals fill the head if it is free after a pop, else the skid.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_sum_s[1:0];
    if (pop_s && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end else begin
      head_d = head_q;
    end
    if (inflight_q) begin
      if (occ_after_pop_s == 2'd0) begin
        head_d = mem_rdata;
      end else begin
        skid_d = mem_rdata;
      end
    end else begin
      skid_d = skid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= {(ASIZE+1){1'b0}};
      rptr_q     <= {(ASIZE+1){1'b0}};
      rempty_q   <= 1'b1;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= {DSIZE{1'b0}};
      skid_q     <= {DSIZE{1'b0}};
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      inflight_q <= mem_ren;
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  assign rptr   = rptr_q;
  assign raddr  = rbin_q[ASIZE-1:0];
  assign rempty = rempty_q;
  assign m_data = head_q;

`ifdef ASYNC_FIFO_RLEVEL_EN
  // Out-of-range thresholds saturate so the flag is simply always set.
  localparam logic [ASIZE:0] AE_W = (AE_LEVEL < (1 << ASIZE)) ? AE_LEVEL[ASIZE:0]
                                                              : {1'b1, {ASIZE{1'b0}}};

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ASIZE:0] rlevel_q, rlevel_d;
  logic           ralmost_q, ralmost_d;

  // Unread RAM words after this cycle's read; excludes buffered and in-flight words.
  always_comb begin
    rlevel_d  = gray2bin(rq2_wptr) - rbin_d;
    ralmost_d = (rlevel_d <= AE_W);
  end

  // Level and almost-empty registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel_q  <= {(ASIZE+1){1'b0}};
      ralmost_q <= 1'b1;
    end else begin
      rlevel_q  <= rlevel_d;
      ralmost_q <= ralmost_d;
    end
  end

  assign rlevel        = rlevel_q;
  assign ralmost_empty = ralmost_q;
`else
  assign rlevel = {(ASIZE+1){1'b0}};
  // Without the counter the flag collapses onto rempty; an out-of-range threshold keeps it set.
  if (AE_LEVEL < (1 << ASIZE)) begin : g_ae_flag
    assign ralmost_empty = rempty_q;
  end else begin : g_ae_flag_sat
    assign ralmost_empty = 1'b1;
  end
`endif

endmodule

// File: tb/tb_rptr_rd_ctrl.sv
// Self-checking bench for rptr_rd_ctrl: RAM/write-side model plus a data scoreboard and per-cycle pointer/flag model.
module tb_rptr_rd_ctrl;

  localparam int ASIZE    = 4;
  localparam int DSIZE    = 8;
  localparam int AE_LEVEL = 1;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       mem_ren;
  logic [7:0] mem_rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       rempty;
  logic [4:0] rlevel;
  logic       ralmost_empty;

  logic [7:0] ram [16];
  logic [4:0] wbin;
  logic [4:0] issued;
  logic       rst_at_edge;
  logic [7:0] sb [$];
  int         n_total;
  int         n_bad;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  rptr_rd_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AE_LEVEL(AE_LEVEL)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .rempty(rempty), .rlevel(rlevel), .ralmost_empty(ralmost_empty)
  );

  always #5 rclk = ~rclk;

  assign rq2_wptr = gray5(wbin);

  // RAM with 1-cycle read latency, read-issue counter and reset tracker.
  always @(posedge rclk) begin
    if (mem_ren) mem_rdata <= ram[raddr];
    if (rrst) issued <= 5'd0;
    else if (mem_ren) issued <= issued + 5'd1;
    rst_at_edge <= rrst;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must be the oldest written one.
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(m_valid), 32'd0);
      end else begin
        logic [7:0] exp_w;
        exp_w = sb.pop_front();
        check_eq("sb_data", 32'(m_data), 32'(exp_w));
      end
    end
  end

  task automatic check_cycle();
    if (rst_at_edge) begin
      check_eq("rst_rempty", 32'(rempty), 32'd1);
      check_eq("rst_mvalid", 32'(m_valid), 32'd0);
      check_eq("rst_mren", 32'(mem_ren), 32'd0);
      check_eq("rst_rptr", 32'(rptr), 32'd0);
      check_eq("rst_rlevel", 32'(rlevel), 32'd0);
      check_eq("rst_ralmost", 32'(ralmost_empty), 32'd1);
      check_eq("rst_mdata", 32'(m_data), 32'd0);
    end else begin
      check_eq("rempty", 32'(rempty), 32'(issued == wbin));
      check_eq("rptr", 32'(rptr), 32'(gray5(issued)));
`ifdef ASYNC_FIFO_RLEVEL_EN
      begin
        logic [4:0] lvl;
        lvl = wbin - issued;
        check_eq("rlevel", 32'(rlevel), 32'(lvl));
        check_eq("ralmost", 32'(ralmost_empty), 32'(lvl <= 5'd1));
      end
`else
      check_eq("rlevel", 32'(rlevel), 32'd0);
      check_eq("ralmost", 32'(ralmost_empty), 32'(issued == wbin));
`endif
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
    check_cycle();
  endtask

  task automatic write_word(input logic [7:0] d);
    ram[wbin[3:0]] = d;
    wbin = wbin + 5'd1;
    sb.push_back(d);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wbin = 5'd0;
    step();
    rrst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  found;
    int  written;
    rrst    = 1'b1;
    wbin    = 5'd0;
    m_ready = 1'b0;
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    step();
    step();
    rrst = 1'b0;

    // Idle after reset with an empty RAM.
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_mvalid", 32'(m_valid), 32'd0);
      check_eq("idle_mren", 32'(mem_ren), 32'd0);
    end

    // Single word: issue latency and c+2 output.
    m_ready = 1'b1;
    write_word(8'hA5);
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      lat++;
      if (mem_ren) found = 1'b1;
    end
    if (found) check_eq("first_ren_lat", 32'(lat), 32'd1);
    else check_eq("tmo_first_ren", 32'(mem_ren), 32'd1);
    step();
    check_eq("single_c1_mvalid", 32'(m_valid), 32'd0);
    step();
    check_eq("single_c2_mvalid", 32'(m_valid), 32'd1);
    check_eq("single_c2_mdata", 32'(m_data), 32'hA5);
    step();
    check_eq("single_after_mvalid", 32'(m_valid), 32'd0);
    check_eq("single_after_rempty", 32'(rempty), 32'd1);
    check_eq("single_after_rptr", 32'(rptr), 32'd1);

    // Full 16-word burst with no bubbles.
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    m_ready = 1'b1;
    for (int i = 0; i < 10 && !m_valid; i++) step();
    if (!m_valid) check_eq("tmo_burst", 32'(m_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq("burst_valid", 32'(m_valid), 32'd1);
      step();
    end
    check_eq("burst_end_mvalid", 32'(m_valid), 32'd0);
    check_eq("burst_left", 32'(sb.size()), 32'd0);
    check_eq("burst_rptr", 32'(rptr), 32'h18);

    // Backpressure: two reads fill the buffer, head held stable.
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_valid) check_eq("hold_mdata", 32'(m_data), 32'h00);
    end
    check_eq("bp_ren_count", 32'(issued), 32'd2);
    check_eq("bp_mvalid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    check_eq("bp_drain", 32'(sb.size()), 32'd0);
    step();
    check_eq("bp_end_mvalid", 32'(m_valid), 32'd0);
    check_eq("bp_rptr", 32'(rptr), 32'h18);

    // Pointer wrap: writer stays at most 3 words ahead, random backpressure.
    do_reset();
    written = 0;
    for (int cyc = 0; cyc < 600 && !(written == 40 && sb.size() == 0); cyc++) begin
      if (written < 40 && sb.size() < 3) begin
        write_word(8'($urandom));
        written++;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check_eq("wrap_drain", 32'(sb.size()), 32'd0);
    check_eq("wrap_reads", 32'(issued), 32'd8);
    check_eq("wrap_rptr", 32'(rptr), 32'(gray5(5'd8)));

    // Five pending words held back: level counts down as two reads issue.
    do_reset();
    for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("lvl_ren_count", 32'(issued), 32'd2);
    m_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check_eq("lvl_drain", 32'(sb.size()), 32'd0);

    // Reset in the middle of a burst; the pending RAM return must be dropped.
    do_reset();
    for (int i = 0; i < 6; i++) write_word(8'(8'hC0 + i));
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rrst = 1'b1;
    sb.delete();
    step();
    wbin = 5'd0;
    rrst = 1'b0;
    step();
    check_eq("midrst_mvalid", 32'(m_valid), 32'd0);
    step();
    check_eq("midrst_mvalid2", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
